uart_tx_dev: RTL and testbench

// - Memory-mapped UART transmitter; a responder on the Ibex data-bus protocol (req/gnt/rvalid).
// - Sits beside the SRAM behind the top-level address decoder; the decoder drives req_i only for its window.
// - Buffers bytes in a TX FIFO and serialises them 8N1, LSB first, on tx_o.

---
 rtl/uart_tx_dev_if.sv | 22 ++
 rtl/uart_tx_dev.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_dev_if.sv
// Ibex-style data-bus bundle (req/gnt/rvalid) between a bus host and the UART TX device.
interface uart_tx_dev_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, responding on the Ibex data-bus protocol.
module uart_tx_dev #(
  parameter int unsigned FifoDepth   = 8,
  parameter logic [15:0] ClkDivReset = 16'd867
) (
  input  logic         clk_i,
  input  logic         rst_i,
  uart_tx_dev_if.slave bus_io,
  output logic         tx_o,
  output logic         irq_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);

  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegClkDiv = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   frameDiv_q, frameDiv_d;

  logic [7:0]    mem_q [FifoDepth];
  logic [PtrW:0] wrPtr_q, wrPtr_d;
  logic [PtrW:0] rdPtr_q, rdPtr_d;
  logic [PtrW:0] level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [15:0]   clkDiv_q, clkDiv_d;
  logic [1:0]    ctrl_q, ctrl_d;

  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          irq_q, irq_d;

  logic [1:0]    regSel;
  logic          txWrite;
  logic [31:0]   readValue;
  logic          unusedBits;

  assign unusedBits = ^{bus_io.addr[31:4], bus_io.addr[1:0], bus_io.be[3:2], bus_io.wdata[31:16]};

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign level = wrPtr_q - rdPtr_q;
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[PtrW] != rdPtr_q[PtrW]) &&
                 (wrPtr_q[PtrW-1:0] == rdPtr_q[PtrW-1:0]);

  // Grant stalls only for a real push into a full FIFO; a pop in the same cycle does not help.
  assign regSel     = bus_io.addr[3:2];
  assign txWrite    = bus_io.req & bus_io.we & (regSel == RegTxData) & bus_io.be[0];
  assign bus_io.gnt = bus_io.req & ~(txWrite & full);
  assign push       = bus_io.gnt & txWrite;

  assign wrPtr_d = wrPtr_q + {{PtrW{1'b0}}, push};
  assign rdPtr_d = rdPtr_q + {{PtrW{1'b0}}, pop};

  always_comb begin
    readValue = '0;
    unique case (regSel)
      RegStatus: begin
        readValue[0]    = full;
        readValue[1]    = empty;
        readValue[2]    = (state_q != StIdle);
        readValue[15:8] = 8'(level);
      end
      RegClkDiv: readValue[15:0] = clkDiv_q;
      RegCtrl:   readValue[1:0]  = ctrl_q;
      default:   readValue       = '0;
    endcase
  end

  always_comb begin
    clkDiv_d = clkDiv_q;
    ctrl_d   = ctrl_q;
    if (bus_io.gnt && bus_io.we) begin
      unique case (regSel)
        RegClkDiv: begin
          if (bus_io.be[0]) clkDiv_d[7:0]  = bus_io.wdata[7:0];
          if (bus_io.be[1]) clkDiv_d[15:8] = bus_io.wdata[15:8];
        end
        RegCtrl: begin
          if (bus_io.be[0]) ctrl_d = bus_io.wdata[1:0];
        end
        default: begin
          ctrl_d = ctrl_q;
        end
      endcase
    end
  end

  // Response is captured in the grant cycle and presented exactly one cycle later.
  assign rvalid_d = bus_io.gnt;
  assign rdata_d  = (bus_io.gnt && !bus_io.we) ? readValue : 32'h0;
  assign err_d    = bus_io.gnt & bus_io.we & (regSel == RegStatus);
  assign irq_d    = ctrl_q[1] & empty & (state_q == StIdle);

  assign bus_io.rvalid = rvalid_q;
  assign bus_io.rdata  = rdata_q;
  assign bus_io.err    = err_q;
  assign irq_o         = irq_q;

  // Frame bit timing is latched into frameDiv at pop so CLKDIV writes only affect later frames.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    frameDiv_d = frameDiv_q;
    pop        = 1'b0;
    tx_o       = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (ctrl_q[0] && !empty) begin
          pop        = 1'b1;
          shift_d    = mem_q[rdPtr_q[PtrW-1:0]];
          frameDiv_d = clkDiv_q;
          baud_d     = clkDiv_q;
          state_d    = StStart;
        end
      end
      StStart: begin
        tx_o = 1'b0;
        if (baud_q == 16'd0) begin
          baud_d   = frameDiv_q;
          bitCnt_d = 3'd0;
          state_d  = StData;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StData: begin
        tx_o = shift_q[0];
        if (baud_q == 16'd0) begin
          baud_d  = frameDiv_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bitCnt_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StStop: begin
        tx_o = 1'b1;
        if (baud_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q[PtrW-1:0]] <= bus_io.wdata[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      frameDiv_q <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      clkDiv_q   <= ClkDivReset;
      ctrl_q     <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      frameDiv_q <= frameDiv_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      clkDiv_q   <= clkDiv_d;
      ctrl_q     <= ctrl_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomised bench for uart_tx_dev: a cycle-level frame/FIFO model scores every cycle, plus directed literal checks.
module tb_uart_tx_dev;
  localparam int Depth = 8;
  localparam logic [1:0] SelTx     = 2'd0;
  localparam logic [1:0] SelStatus = 2'd1;
  localparam logic [1:0] SelDiv    = 2'd2;
  localparam logic [1:0] SelCtrl   = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txLine;
  logic irqLine;
  int   checks = 0;
  int   errors = 0;

  uart_tx_dev_if busIf ();

  uart_tx_dev #(
    .FifoDepth  (Depth),
    .ClkDivReset(16'd867)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(busIf),
    .tx_o  (txLine),
    .irq_o (irqLine)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: FIFO as a queue, a frame as "cycles elapsed since start bit" over 10*(div+1) cycles.
  logic [7:0]  q[$];
  bit          modelValid = 1'b0;
  bit          active = 1'b0;
  int          elapsed = 0;
  int          fdiv = 0;
  logic [7:0]  fbyte = 8'h0;
  logic [15:0] mClkDiv = 16'd867;
  logic [1:0]  mCtrl = 2'b00;
  logic        expRvalid = 1'b0;
  logic        expErr = 1'b0;
  logic        expIrq = 1'b0;
  logic [31:0] expRdata = 32'h0;

  always @(negedge clk) begin : scoreboard
    logic        full, empty, txWrite, expGnt, expTx, doPop, nextIrq, nowBusy;
    logic [1:0]  sel;
    logic [31:0] readVal;
    int          k;
    sel     = busIf.addr[3:2];
    full    = (q.size() == Depth);
    empty   = (q.size() == 0);
    nowBusy = active;
    txWrite = busIf.req && busIf.we && (sel == SelTx) && busIf.be[0];
    expGnt  = busIf.req && !(txWrite && full);
    if (!active) begin
      expTx = 1'b1;
    end else begin
      k = elapsed / (fdiv + 1);
      if (k == 0)      expTx = 1'b0;
      else if (k == 9) expTx = 1'b1;
      else             expTx = fbyte[k-1];
    end
    if (modelValid) begin
      checkOutput("gnt", busIf.gnt, expGnt);
      checkOutput("tx", txLine, expTx);
      checkOutput("irq", irqLine, expIrq);
      checkOutput("rvalid", busIf.rvalid, expRvalid);
      checkOutput("err", busIf.err, expErr);
      if (expRvalid) checkOutput("rdata", busIf.rdata, expRdata);
    end
    if (rst) begin
      modelValid = 1'b1;
      q.delete();
      active    = 1'b0;
      elapsed   = 0;
      mClkDiv   = 16'd867;
      mCtrl     = 2'b00;
      expRvalid = 1'b0;
      expErr    = 1'b0;
      expIrq    = 1'b0;
      expRdata  = 32'h0;
    end else begin
      nextIrq = mCtrl[1] && empty && !active;
      doPop   = !active && mCtrl[0] && !empty;
      case (sel)
        SelStatus: readVal = {16'h0, 8'(q.size()), 5'h0, nowBusy, empty, full};
        SelDiv:    readVal = {16'h0, mClkDiv};
        SelCtrl:   readVal = {30'h0, mCtrl};
        default:   readVal = 32'h0;
      endcase
      expRvalid = expGnt;
      expRdata  = (expGnt && !busIf.we) ? readVal : 32'h0;
      expErr    = expGnt && busIf.we && (sel == SelStatus);
      expIrq    = nextIrq;
      if (active) begin
        elapsed++;
        if (elapsed == 10 * (fdiv + 1)) active = 1'b0;
      end else if (doPop) begin
        fbyte   = q.pop_front();
        fdiv    = int'(mClkDiv);
        elapsed = 0;
        active  = 1'b1;
      end
      if (expGnt && busIf.we) begin
        if (sel == SelTx && busIf.be[0]) q.push_back(busIf.wdata[7:0]);
        if (sel == SelDiv && busIf.be[0]) mClkDiv[7:0] = busIf.wdata[7:0];
        if (sel == SelDiv && busIf.be[1]) mClkDiv[15:8] = busIf.wdata[15:8];
        if (sel == SelCtrl && busIf.be[0]) mCtrl = busIf.wdata[1:0];
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] rdata, output logic err);
    logic [31:0] noise;
    bit          granted;
    noise   = $urandom();
    granted = 1'b0;
    @(posedge clk); #2;
    busIf.req   = 1'b1;
    busIf.we    = we;
    busIf.addr  = {noise[31:4], sel, noise[1:0]};
    busIf.wdata = wdata;
    busIf.be    = be;
    for (int i = 0; i < 200 && !granted; i++) begin
      @(negedge clk);
      granted = (busIf.gnt === 1'b1);
      @(posedge clk); #2;
    end
    busIf.req = 1'b0;
    busIf.we  = 1'b0;
    rdata = 32'h0;
    err   = 1'b0;
    if (!granted) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout sel=%0d no gnt within 200 cycles", sel);
    end else begin
      @(negedge clk);
      rdata = busIf.rdata;
      err   = busIf.err;
    end
  endtask

  task automatic busWrite(input logic [1:0] sel, input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] rd;
    logic        e;
    applyStimulus(1'b1, sel, wdata, be, rd, e);
  endtask

  task automatic busRead(input logic [1:0] sel, output logic [31:0] rdata, output logic err);
    applyStimulus(1'b0, sel, 32'h0, 4'hF, rdata, err);
  endtask

  task automatic waitIdle();
    logic [31:0] st;
    logic        e;
    bit          done;
    done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      busRead(SelStatus, st, e);
      if ((st & 32'h0000_FF06) == 32'h0000_0002) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout last status=0x%08h", st);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [39:0] wave;
    bit          found;
    int          n;
    busIf.req   = 1'b0;
    busIf.we    = 1'b0;
    busIf.be    = 4'h0;
    busIf.addr  = 32'h0;
    busIf.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    busRead(SelStatus, rd, e);
    checkOutput("reset_status", rd, 32'h0000_0002);
    checkOutput("reset_err", e, 1'b0);
    checkOutput("reset_tx", txLine, 1'b1);
    checkOutput("reset_irq", irqLine, 1'b0);

    $display("[TB] frame shape, CLKDIV=3 byte 0x55");
    busWrite(SelDiv, 32'h3, 4'hF);
    busWrite(SelCtrl, 32'h1, 4'hF);
    busWrite(SelTx, 32'h55, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (txLine == 1'b0) found = 1'b1;
    end
    checkOutput("start_seen", found, 1'b1);
    wave = 40'h0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      wave = {wave[38:0], txLine};
    end
    checkOutput("frame_0x55", wave, 40'h0F0F0F0F0F);
    busRead(SelStatus, rd, e);
    checkOutput("busy_cleared", rd, 32'h0000_0002);

    $display("[TB] fill FIFO with tx disabled, then release");
    busWrite(SelDiv, 32'h0, 4'hF);
    busWrite(SelCtrl, 32'h0, 4'hF);
    for (int i = 0; i < Depth; i++) busWrite(SelTx, $urandom_range(0, 255), 4'h1);
    busRead(SelStatus, rd, e);
    checkOutput("full_status", rd, 32'h0000_0801);
    @(posedge clk); #2;
    busIf.req = 1'b1; busIf.we = 1'b1; busIf.addr = 32'h0; busIf.wdata = 32'hA5; busIf.be = 4'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ninth_stall", busIf.gnt, 1'b0);
      @(posedge clk); #2;
    end
    busIf.addr = 32'hC; busIf.wdata = 32'h1; busIf.be = 4'hF;
    @(negedge clk);
    checkOutput("ctrl_gnt", busIf.gnt, 1'b1);
    @(posedge clk); #2;
    busIf.addr = 32'h0; busIf.wdata = 32'hA5; busIf.be = 4'h1;
    @(negedge clk);
    checkOutput("pop_cycle_no_bypass", busIf.gnt, 1'b0);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("ninth_gnt", busIf.gnt, 1'b1);
    @(posedge clk); #2;
    busIf.req = 1'b0; busIf.we = 1'b0;
    waitIdle();

    $display("[TB] STATUS write error and masked TXDATA write");
    applyStimulus(1'b1, SelStatus, 32'hFFFF_FFFF, 4'hF, rd, e);
    checkOutput("status_write_err", e, 1'b1);
    busRead(SelStatus, rd, e);
    checkOutput("status_unchanged", rd, 32'h0000_0002);
    applyStimulus(1'b1, SelTx, 32'h77, 4'hE, rd, e);
    checkOutput("masked_tx_err", e, 1'b0);
    busRead(SelStatus, rd, e);
    checkOutput("masked_tx_nopush", rd, 32'h0000_0002);

    $display("[TB] interrupt after two frames");
    busWrite(SelCtrl, 32'h0, 4'hF);
    busWrite(SelDiv, 32'h1, 4'hF);
    busWrite(SelTx, 32'h3C, 4'h1);
    busWrite(SelTx, 32'hA1, 4'h1);
    busWrite(SelCtrl, 32'h3, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (txLine == 1'b0) found = 1'b1;
    end
    checkOutput("irq_start_seen", found, 1'b1);
    n = 0;
    for (int i = 1; i <= 60 && n == 0; i++) begin
      @(negedge clk);
      if (irqLine == 1'b1) n = i;
    end
    checkOutput("irq_latency", n, 42);

    $display("[TB] clear tx_en mid-frame, then reset mid-bit");
    busWrite(SelCtrl, 32'h1, 4'hF);
    busWrite(SelDiv, 32'h3, 4'hF);
    busWrite(SelTx, 32'hC3, 4'h1);
    busWrite(SelTx, 32'h00, 4'h1);
    busWrite(SelCtrl, 32'h0, 4'hF);
    repeat (60) @(posedge clk);
    busRead(SelStatus, rd, e);
    checkOutput("held_status", rd, 32'h0000_0100);
    checkOutput("held_tx", txLine, 1'b1);
    busWrite(SelCtrl, 32'h1, 4'hF);
    busWrite(SelTx, 32'h99, 4'h1);
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput("pre_reset_data_bit", txLine, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_tx", txLine, 1'b1);
    busRead(SelStatus, rd, e);
    checkOutput("post_reset_status", rd, 32'h0000_0002);
    busRead(SelDiv, rd, e);
    checkOutput("post_reset_clkdiv", rd, 32'h0000_0363);

    $display("[TB] randomised traffic");
    busWrite(SelDiv, 32'h1, 4'hF);
    busWrite(SelCtrl, 32'h1, 4'hF);
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: busWrite(SelTx, $urandom_range(0, 255), 4'($urandom()) | 4'h1);
        4:          busRead(2'($urandom_range(0, 3)), rd, e);
        5:          busWrite(SelDiv, $urandom_range(0, 3), 4'($urandom()));
        6:          busWrite(SelCtrl, {30'h0, 1'($urandom()), 1'b1}, 4'($urandom()));
        7:          busWrite(SelStatus, $urandom(), 4'($urandom()));
        8:          repeat ($urandom_range(0, 5)) @(posedge clk);
        default:    busWrite(SelTx, $urandom_range(0, 255), 4'($urandom()));
      endcase
    end
    waitIdle();
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
